// File: rtl/bist_pkg.sv
// Shared types and default widths for the BIST controller and its pattern counter.
package bist_pkg;

    localparam int DEF_CNT_W = 10;
    localparam int DEF_SIG_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } bist_state_t;

endpackage

// File: rtl/bist_pat_counter.sv
// Pattern counter: synchronous clear, count enable, terminal-count flag at N_PAT-1.
module bist_pat_counter
    import bist_pkg::*;
#(
    parameter int N_PAT = 1000,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Equality exit means the count never needs to wrap within a run.
    assign tc = (count == CNT_W'(N_PAT - 1));

endmodule

// File: rtl/bist_controller.sv
// BIST run sequencer: start edge detect, TPG/MISR control FSM and pass/fail verdict.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               N_PAT      = 1000,
    parameter int               CNT_W      = DEF_CNT_W,
    parameter int               SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] sig_in,
    output logic             tpg_init,
    output logic             tpg_en,
    output logic             misr_init,
    output logic             misr_en,
    output logic             test_mode,
    output logic             running,
    output logic             bist_end,
    output logic             out
);

    bist_state_t state, next_state;
    logic        start_q;
    logic        start_rise;
    logic        result;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;

    // start_q resets high so a start held through reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start;
        end
    end

    assign start_rise = start & ~start_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result <= 1'b0;
        end else if (state == CMP) begin
            result <= (sig_in == GOLDEN_SIG);
        end
    end

    assign cnt_clr = (state == INIT);
    assign cnt_en  = (state == RUN);

    bist_pat_counter #(
        .N_PAT (N_PAT),
        .CNT_W (CNT_W)
    ) u_pat_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_rise) next_state = INIT;
            INIT:    next_state = RUN;
            RUN:     if (cnt_tc) next_state = FLUSH;
            FLUSH:   next_state = CMP;
            CMP:     next_state = DONE;
            DONE:    if (start_rise) next_state = INIT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tpg_init  = 1'b0;
        tpg_en    = 1'b0;
        misr_init = 1'b0;
        misr_en   = 1'b0;
        test_mode = 1'b0;
        running   = 1'b0;
        bist_end  = 1'b0;
        out       = 1'b0;
        case (state)
            INIT: begin
                tpg_init  = 1'b1;
                misr_init = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
            end
            RUN: begin
                tpg_en    = 1'b1;
                misr_en   = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
            end
            FLUSH: begin
                misr_en   = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
            end
            CMP: begin
                test_mode = 1'b1;
                running   = 1'b1;
            end
            DONE: begin
                bist_end = 1'b1;
                out      = result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: cycle-offset reference model feeding a scoreboard queue.
module tb_bist_controller;

    localparam int          N    = 8;
    localparam int          CW   = 4;
    localparam int          SW   = 16;
    localparam logic [15:0] GOLD = 16'hA5C3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] sig_in = '0;
    logic tpg_init, tpg_en, misr_init, misr_en, test_mode, running, bist_end, out;

    bist_controller #(
        .N_PAT      (N),
        .CNT_W      (CW),
        .SIG_W      (SW),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sig_in    (sig_in),
        .tpg_init  (tpg_init),
        .tpg_en    (tpg_en),
        .misr_init (misr_init),
        .misr_en   (misr_en),
        .test_mode (test_mode),
        .running   (running),
        .bist_end  (bist_end),
        .out       (out)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    // Model: ph is the number of cycles since the accepted start edge (0 = idle),
    // saturating at N+4 once the result is being presented.
    int          ph = 0;
    bit          m_prev = 1'b1;
    bit          m_verdict = 1'b0;
    logic [15:0] cmp_sig = GOLD;

    function automatic logic [7:0] expected_outputs(int p, bit verdict);
        bit t_init, t_en, m_init, m_en, tmode, run, bend, o;
        t_init = (p == 1);
        t_en   = (p >= 2) && (p <= N + 1);
        m_init = (p == 1);
        m_en   = (p >= 2) && (p <= N + 2);
        tmode  = (p >= 1) && (p <= N + 3);
        run    = (p >= 1) && (p <= N + 3);
        bend   = (p == N + 4);
        o      = bend && verdict;
        return {t_init, t_en, m_init, m_en, tmode, run, bend, o};
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [15:0] sig);
        bit rise;
        if (!r) begin
            ph        = 0;
            m_prev    = 1'b1;
            m_verdict = 1'b0;
        end else begin
            rise   = s && !m_prev;
            m_prev = s;
            if (ph == 0 || ph == N + 4) begin
                if (rise) ph = 1;
            end else begin
                if (ph == N + 3) m_verdict = (sig == GOLD);
                ph++;
            end
        end
        exp_q.push_back(expected_outputs(ph, m_verdict));
    endtask

    task automatic cycle(input bit r, input bit s);
        rst    = r;
        start  = s;
        sig_in = (ph == N + 3) ? cmp_sig : 16'($urandom);
        model_edge(r, s, sig_in);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
    endtask

    task automatic finish_run(input bit noise);
        int guard;
        guard = 0;
        while (ph != N + 4 && ph != 0 && guard < 4 * N) begin
            cycle(1'b1, noise ? 1'($urandom_range(0, 1)) : 1'b0);
            guard++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    endtask

    // Monitor: one scoreboard entry per clock edge, plus per-run strobe counts.
    initial begin
        logic [7:0] e, a;
        int  c_ti, c_te, c_mi, c_me;
        bit  prev_end;
        c_ti = 0; c_te = 0; c_mi = 0; c_me = 0;
        prev_end = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {tpg_init, tpg_en, misr_init, misr_en, test_mode, running, bist_end, out};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d {ti,te,mi,me,tm,run,end,out} actual=%b required=%b",
                             cyc, a, e);
                end
                if (a[2] !== 1'b1 && a[1] !== 1'b1) begin
                    c_ti = 0; c_te = 0; c_mi = 0; c_me = 0;
                end
                c_ti += int'(a[7] === 1'b1);
                c_te += int'(a[6] === 1'b1);
                c_mi += int'(a[5] === 1'b1);
                c_me += int'(a[4] === 1'b1);
                if (a[1] === 1'b1 && !prev_end) begin
                    n_cmp += 4;
                    if (c_ti != 1) begin n_bad++; $display("FAIL tpg_init_count actual=%0d required=1", c_ti); end
                    if (c_te != N) begin n_bad++; $display("FAIL tpg_en_count actual=%0d required=%0d", c_te, N); end
                    if (c_mi != 1) begin n_bad++; $display("FAIL misr_init_count actual=%0d required=1", c_mi); end
                    if (c_me != N + 1) begin n_bad++; $display("FAIL misr_en_count actual=%0d required=%0d", c_me, N + 1); end
                    c_ti = 0; c_te = 0; c_mi = 0; c_me = 0;
                end
                prev_end = (a[1] === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start low, then a passing run.
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cmp_sig = GOLD;
        pulse_start();
        finish_run(1'b0);

        // Restart from DONE with a near-miss signature.
        cmp_sig = 16'hA5C2;
        pulse_start();
        finish_run(1'b0);

        // Second start pulse mid-RUN is ignored.
        cmp_sig = GOLD;
        pulse_start();
        while (ph != N + 4) cycle(1'b1, (ph == 5 || ph == 6));
        finish_run(1'b0);

        // Reset for two cycles while the counter is at 4, then a full run.
        pulse_start();
        while (ph != 6) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        pulse_start();
        finish_run(1'b0);

        // Start held through reset release must not launch a run.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
        pulse_start();
        finish_run(1'b0);

        // Randomized runs with start noise and random verdicts.
        for (int r = 0; r < 10; r++) begin
            cmp_sig = ($urandom_range(0, 1) == 1) ? GOLD : (GOLD ^ 16'(1 << $urandom_range(0, 15)));
            pulse_start();
            finish_run(1'b1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) cycle(1'b1, 1'b0);
        end

        cycle(1'b1, 1'b0);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
